// File: rtl/exec_sequencer.sv
// Multi-cycle control sequencer for the 8-bit computer: fetches from ROM, sequences
// register reads/writes, RAM accesses, TTY output and branches. All outputs are registered.
module exec_sequencer #(
  parameter logic [7:0]  PC_RESET     = 8'h00,
  parameter logic [15:0] RETIRE_LIMIT = 16'd0
) (
  input  logic        clock,
  input  logic        reset,
  output logic [7:0]  rom_address,
  input  logic [15:0] rom_data,
  output logic [3:0]  reg_read1_id,
  input  logic [7:0]  reg_read1_value,
  output logic [3:0]  reg_read2_id,
  input  logic [7:0]  reg_read2_value,
  output logic [3:0]  reg_write_id,
  output logic [7:0]  reg_write_value,
  output logic [7:0]  ram_address,
  input  logic [7:0]  ram_data,
  output logic        ram_write,
  output logic [7:0]  ram_write_data,
  output logic [7:0]  tty_data,
  output logic        tty_valid,
  input  logic        tty_ready,
  output logic        halted,
  output logic        limit_hit,
  output logic        bad_syscall,
  output logic [15:0] retired
);
  typedef enum logic [2:0] {FETCH, READ, EXEC, WB, TTY, HALT} state_t;

  state_t      state;
  logic [7:0]  pc, opa, opb, pc_inc, pc_next, wr_val;
  logic [15:0] ir, retired_inc;
  logic [3:0]  op, a1, wr_id, rd1, rd2;
  logic [7:0]  mid, imm;
  logic        wr_en, limit_reached;

  assign rom_address   = pc;
  assign op            = ir[15:12];
  assign a1            = ir[11:8];
  assign mid           = ir[11:4];
  assign imm           = ir[7:0];
  assign pc_inc        = pc + 8'd1;
  assign retired_inc   = (retired == 16'hFFFF) ? retired : retired + 16'd1;
  assign limit_reached = (RETIRE_LIMIT != 16'd0) && (retired_inc == RETIRE_LIMIT);

  // Read selects are decoded straight from the ROM word so they are valid throughout READ.
  always_comb begin
    rd1 = 4'd0;
    rd2 = 4'd0;
    case (rom_data[15:12])
      4'h1, 4'h6:             rd1 = rom_data[7:4];
      4'h3, 4'h7, 4'hB:       begin rd1 = rom_data[11:8]; rd2 = rom_data[7:4]; end
      4'h4, 4'h5, 4'hA:       rd1 = rom_data[11:8];
      4'h8:                   begin rd1 = 4'd8; rd2 = 4'd1; end
      4'hC, 4'hD, 4'hE, 4'hF: rd1 = 4'd9;
      default: ;
    endcase
  end

  // Result computed from live read data in READ and registered so the write lands in EXEC.
  always_comb begin
    wr_en  = 1'b1;
    wr_id  = a1;
    wr_val = 8'd0;
    case (op)
      4'h1: wr_val = reg_read1_value;
      4'h2: wr_val = imm;
      4'h3: wr_val = reg_read1_value + reg_read2_value;
      4'h4: wr_val = reg_read1_value + imm;
      4'h5: wr_val = ~reg_read1_value + 8'd1;
      4'hB: begin
        wr_id  = 4'd9;
        wr_val = (reg_read1_value < reg_read2_value) ? 8'd1 :
                 (reg_read1_value == reg_read2_value) ? 8'd2 : 8'd3;
      end
      default: wr_en = 1'b0;
    endcase
  end

  always_comb begin
    pc_next = pc_inc;
    case (op)
      4'h9: pc_next = mid;
      4'hA: pc_next = opa;
      4'hC: if (opa == 8'd2) pc_next = mid;
      4'hD: if (opa == 8'd1) pc_next = mid;
      4'hE: if (opa == 8'd3) pc_next = mid;
      4'hF: if (opa != 8'd2) pc_next = mid;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= FETCH;          pc <= PC_RESET;         ir <= 16'd0;
      opa <= 8'd0;             opb <= 8'd0;
      reg_read1_id <= 4'd0;    reg_read2_id <= 4'd0;
      reg_write_id <= 4'd0;    reg_write_value <= 8'd0;
      ram_address <= 8'd0;     ram_write <= 1'b0;      ram_write_data <= 8'd0;
      tty_data <= 8'd0;        tty_valid <= 1'b0;
      halted <= 1'b0;          limit_hit <= 1'b0;      bad_syscall <= 1'b0;
      retired <= 16'd0;
    end else begin
      case (state)
        FETCH: begin
          ir           <= rom_data;
          reg_read1_id <= rd1;
          reg_read2_id <= rd2;
          state        <= READ;
        end
        READ: begin
          opa             <= reg_read1_value;
          opb             <= reg_read2_value;
          reg_read1_id    <= 4'd0;
          reg_read2_id    <= 4'd0;
          reg_write_id    <= wr_en ? wr_id : 4'd0;
          reg_write_value <= wr_en ? wr_val : 8'd0;
          if (op == 4'h6) ram_address <= reg_read1_value;
          if (op == 4'h7) begin
            ram_address    <= reg_read2_value;
            ram_write_data <= reg_read1_value;
            ram_write      <= 1'b1;
          end
          state <= EXEC;
        end
        EXEC: begin
          reg_write_id    <= 4'd0;
          reg_write_value <= 8'd0;
          ram_write       <= 1'b0;
          ram_write_data  <= 8'd0;
          ram_address     <= 8'd0;
          if (op == 4'h6) begin
            reg_write_id    <= a1;
            reg_write_value <= ram_data;
            pc              <= pc_inc;
            state           <= WB;
          end else if (op == 4'h8 && opa == 8'd1) begin
            tty_data  <= opb;
            tty_valid <= 1'b1;
            pc        <= pc_inc;
            state     <= TTY;
          end else if (op == 4'h8 && opa == 8'h0F) begin
            retired   <= retired_inc;
            halted    <= 1'b1;
            limit_hit <= limit_reached;
            state     <= HALT;
          end else begin
            if (op == 4'h8 && opa != 8'd0) bad_syscall <= 1'b1;
            retired   <= retired_inc;
            pc        <= pc_next;
            halted    <= limit_reached;
            limit_hit <= limit_reached;
            state     <= limit_reached ? HALT : FETCH;
          end
        end
        WB: begin
          reg_write_id    <= 4'd0;
          reg_write_value <= 8'd0;
          retired         <= retired_inc;
          halted          <= limit_reached;
          limit_hit       <= limit_reached;
          state           <= limit_reached ? HALT : FETCH;
        end
        TTY: if (tty_ready) begin
          tty_valid <= 1'b0;
          tty_data  <= 8'd0;
          retired   <= retired_inc;
          halted    <= limit_reached;
          limit_hit <= limit_reached;
          state     <= limit_reached ? HALT : FETCH;
        end
        HALT: ;
        default: state <= FETCH;
      endcase
    end
  end
endmodule
